// File: rtl/jedro_1_fetch_ctrl.sv
// rtl/jedro_1_fetch_ctrl.sv - instruction fetch controller: PC sequencing, 1-cycle RAM latency, buffered decode handoff
// Credit-based issue keeps buffered plus in-flight words within FIFO_DEPTH, so the buffer can never overflow.
module jedro_1_fetch_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] BOOT_ADDR  = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    output logic                  ram_en_o,
    output logic [DATA_WIDTH-1:0] ram_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] instr_pc_o,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    input  logic                  jmp_i,
    input  logic [DATA_WIDTH-1:0] jmp_addr_i,
    input  logic                  halt_i
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0] instr_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] pc_mem_q    [FIFO_DEPTH];

    logic        pop;
    logic        push;
    logic        issue;
    logic [CW:0] occupancy;
    logic [1:0]  jmp_addr_unused;

    assign jmp_addr_unused = jmp_addr_i[1:0];

    // Occupancy after this edge's pop; a new issue needs a free slot for its returning word.
    assign occupancy = {1'b0, count_q} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);

    assign instr_valid_o = (count_q != '0) & ~jmp_i;
    assign pop           = instr_valid_o & instr_ready_i;
    assign push          = inflight_q & ~jmp_i;
    assign issue         = rstn_i & ~jmp_i & ~halt_i & (occupancy < (CW + 1)'(FIFO_DEPTH));

    assign ram_en_o   = issue;
    assign ram_addr_o = fetch_pc_q;
    assign instr_o    = instr_mem_q[rd_ptr_q];
    assign instr_pc_o = pc_mem_q[rd_ptr_q];

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        if (jmp_i) begin
            // Redirect flushes everything, including the word returning at this edge.
            fetch_pc_d = {jmp_addr_i[DATA_WIDTH-1:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + DATA_WIDTH'(4);
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fetch_pc_q    <= BOOT_ADDR;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else if (push) begin
            instr_mem_q[wr_ptr_q] <= ram_rdata_i;
            pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rstn_i)
        !(push && !pop && (count_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_jedro_1_fetch_ctrl.sv
// tb/tb_jedro_1_fetch_ctrl.sv - directed self-checking bench for jedro_1_fetch_ctrl
module tb_jedro_1_fetch_ctrl;

    localparam logic [31:0] SALT = 32'hA5A5_0000;

    logic        clk;
    logic        rstn;
    logic        ram_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        jmp;
    logic [31:0] jmp_addr;
    logic        halt;

    int n_cmp;
    int n_bad;

    jedro_1_fetch_ctrl #(
        .DATA_WIDTH(32),
        .BOOT_ADDR (32'h0000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .ram_en_o     (ram_en),
        .ram_addr_o   (ram_addr),
        .ram_rdata_i  (ram_rdata),
        .instr_o      (instr),
        .instr_pc_o   (instr_pc),
        .instr_valid_o(instr_valid),
        .instr_ready_i(instr_ready),
        .jmp_i        (jmp),
        .jmp_addr_i   (jmp_addr),
        .halt_i       (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction RAM: word at address a is a ^ SALT.
    always_ff @(posedge clk) begin
        if (ram_en) ram_rdata <= ram_addr ^ SALT;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Steady streaming with ready=1: head pc, matching data, and fetch running two words ahead.
    task automatic expect_stream(input string tag, input logic [31:0] start_pc, input int n);
        logic [31:0] pc;
        pc = start_pc;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
            chk({tag, "_pc"}, instr_pc, pc);
            chk({tag, "_instr"}, instr, pc ^ SALT);
            chk({tag, "_addr"}, ram_addr, pc + 32'd8);
            step();
            pc = pc + 32'd4;
        end
    endtask

    task automatic jump_to(input string tag, input logic [31:0] target);
        logic [31:0] aligned;
        aligned  = {target[31:2], 2'b00};
        jmp      = 1'b1;
        jmp_addr = target;
        #1;
        chk({tag, "_jcyc_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_jcyc_en"}, {31'd0, ram_en}, 32'd0);
        step();
        jmp = 1'b0;
        #1;
        chk({tag, "_k1_en"}, {31'd0, ram_en}, 32'd1);
        chk({tag, "_k1_addr"}, ram_addr, aligned);
        chk({tag, "_k1_valid"}, {31'd0, instr_valid}, 32'd0);
        step();
        chk({tag, "_k2_valid"}, {31'd0, instr_valid}, 32'd0);
        step();
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rstn        = 1'b0;
        instr_ready = 1'b0;
        jmp         = 1'b0;
        jmp_addr    = '0;
        halt        = 1'b0;

        // Held in reset
        @(negedge clk);
        @(negedge clk);
        chk("rst_en", {31'd0, ram_en}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_addr", ram_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);

        // 1: release and stream from BOOT_ADDR
        rstn        = 1'b1;
        instr_ready = 1'b1;
        #1;
        chk("t1_c0_en", {31'd0, ram_en}, 32'd1);
        chk("t1_c0_addr", ram_addr, 32'h0);
        step();
        chk("t1_c1_addr", ram_addr, 32'h4);
        chk("t1_c1_valid", {31'd0, instr_valid}, 32'd0);
        step();
        expect_stream("t1", 32'h0, 6);

        // 2: backpressure for 6 cycles; head is pc 0x18
        instr_ready = 1'b0;
        #1;
        chk("t2_full_en", {31'd0, ram_en}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_stall_en", {31'd0, ram_en}, 32'd0);
            chk("t2_stall_pc", instr_pc, 32'h18);
            chk("t2_stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        instr_ready = 1'b1;
        #1;
        chk("t2_resume_addr", ram_addr, 32'h20);
        chk("t2_resume_en", {31'd0, ram_en}, 32'd1);
        step();
        expect_stream("t2", 32'h1C, 4);

        // 3: redirect with one buffered and one in-flight word
        jump_to("t3", 32'h0000_0103);
        expect_stream("t3", 32'h100, 3);

        // 4: redirect near top of address space, PC wraps
        jump_to("t4", 32'hFFFF_FFF8);
        expect_stream("t4", 32'hFFFF_FFF8, 4);

        // 5: halt for 4 cycles; head is pc 0x8, pc 0xC in flight
        halt = 1'b1;
        #1;
        chk("t5_h0_en", {31'd0, ram_en}, 32'd0);
        chk("t5_h0_pc", instr_pc, 32'h8);
        step();
        chk("t5_h1_en", {31'd0, ram_en}, 32'd0);
        chk("t5_h1_pc", instr_pc, 32'hC);
        chk("t5_h1_valid", {31'd0, instr_valid}, 32'd1);
        step();
        chk("t5_h2_valid", {31'd0, instr_valid}, 32'd0);
        chk("t5_h2_en", {31'd0, ram_en}, 32'd0);
        step();
        chk("t5_h3_valid", {31'd0, instr_valid}, 32'd0);
        halt = 1'b0;
        #1;
        chk("t5_resume_en", {31'd0, ram_en}, 32'd1);
        chk("t5_resume_addr", ram_addr, 32'h10);
        step();
        chk("t5_r1_valid", {31'd0, instr_valid}, 32'd0);
        chk("t5_r1_addr", ram_addr, 32'h14);
        step();
        expect_stream("t5", 32'h10, 3);

        // 6: asynchronous reset between edges
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_rst_en", {31'd0, ram_en}, 32'd0);
        chk("t6_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("t6_rst_addr", ram_addr, 32'h0);
        step();
        step();
        rstn = 1'b1;
        #1;
        chk("t6_c0_en", {31'd0, ram_en}, 32'd1);
        chk("t6_c0_addr", ram_addr, 32'h0);
        step();
        chk("t6_c1_valid", {31'd0, instr_valid}, 32'd0);
        step();
        expect_stream("t6", 32'h0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
